// File: rtl/hilo_ctrl.sv
// HI/LO register stage around the iterative multiplier: launches a multiply,
// waits out its fixed latency, captures the product, and services MTHI/MTLO/MFHI/MFLO.
module hilo_ctrl #(
    parameter int MULT_LATENCY = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_mult,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic        op_mfhi,
    input  logic        op_mflo,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_low,
    output logic [31:0] value_A_Mc,
    output logic [31:0] value_B_Mp,
    output logic        multInit,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] rd_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, CAPTURE} state_t;

    localparam logic [5:0] CNT_LOAD = 6'(MULT_LATENCY - 1);

    state_t     state;
    logic [5:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            value_A_Mc <= '0;
            value_B_Mp <= '0;
            multInit   <= 1'b0;
            hi_out     <= '0;
            lo_out     <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_mult) begin
                        value_A_Mc <= rs_value;
                        value_B_Mp <= rt_value;
                        multInit   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LAUNCH;
                    end else begin
                        if (op_mthi) hi_out <= rs_value;
                        if (op_mtlo) lo_out <= rs_value;
                    end
                end
                LAUNCH: begin
                    multInit <= 1'b0;
                    cnt      <= CNT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Leave as the count reaches zero so WAIT spans exactly MULT_LATENCY-1 cycles.
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) state <= CAPTURE;
                end
                CAPTURE: begin
                    hi_out <= mult_hi;
                    lo_out <= mult_low;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // No bypass: a same-cycle MTHI/MTLO is not reflected until the next cycle.
    always_comb begin
        rd_data = '0;
        if (op_mfhi)      rd_data = hi_out;
        else if (op_mflo) rd_data = lo_out;
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed + randomized bench for hilo_ctrl with a fixed-latency multiplier stand-in.
module tb_hilo_ctrl;
    localparam int L = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_mult, op_mthi, op_mtlo, op_mfhi, op_mflo;
    logic [31:0] rs_value, rt_value, mult_hi, mult_low;
    logic [31:0] value_A_Mc, value_B_Mp, hi_out, lo_out, rd_data;
    logic        multInit, busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    hilo_ctrl #(.MULT_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .op_mult(op_mult), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
        .op_mfhi(op_mfhi), .op_mflo(op_mflo),
        .rs_value(rs_value), .rt_value(rt_value),
        .mult_hi(mult_hi), .mult_low(mult_low),
        .value_A_Mc(value_A_Mc), .value_B_Mp(value_B_Mp), .multInit(multInit),
        .hi_out(hi_out), .lo_out(lo_out), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: product is valid only in the L-th cycle after the multInit cycle.
    logic [63:0] m_prod;
    int          m_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt  <= 0;
            m_prod <= '0;
        end else if (multInit) begin
            m_cnt  <= 1;
            m_prod <= {32'b0, value_A_Mc} * {32'b0, value_B_Mp};
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign mult_hi  = (m_cnt == L) ? m_prod[63:32] : 32'hBAD0BAD0;
    assign mult_low = (m_cnt == L) ? m_prod[31:0]  : 32'hBAD1BAD1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd();
        logic [31:0] e;
        e = op_mfhi ? ref_hi : (op_mflo ? ref_lo : 32'h0);
        #1;
        chk("rd_data", rd_data, e);
    endtask

    // Issue a MULT in the current IDLE cycle and follow it to completion (cycle L+2).
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] rs_after, input bit hold_mult);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        op_mult = 1'b1; rs_value = a; rt_value = b;
        step();
        chk("c1_multInit", multInit, 1);
        chk("c1_busy", busy, 1);
        chk("c1_hi_kept", hi_out, ref_hi);
        chk("c1_opA", value_A_Mc, a);
        chk("c1_opB", value_B_Mp, b);
        if (!hold_mult) op_mult = 1'b0;
        op_mthi = 1'b0;
        rs_value = rs_after; rt_value = $urandom;
        for (int c = 2; c <= L + 1; c++) begin
            step();
            chk("wait_multInit", multInit, 0);
            chk("wait_busy", busy, 1);
            chk("wait_lo_kept", lo_out, ref_lo);
        end
        step();
        chk("done_busy", busy, 0);
        chk("done_multInit", multInit, 0);
        chk("done_hi", hi_out, p[63:32]);
        chk("done_lo", lo_out, p[31:0]);
        chk("done_opA_kept", value_A_Mc, a);
        ref_hi = p[63:32];
        ref_lo = p[31:0];
    endtask

    initial begin
        reset = 1'b1;
        op_mult = 0; op_mthi = 0; op_mtlo = 0; op_mfhi = 0; op_mflo = 0;
        rs_value = '0; rt_value = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_multInit", multInit, 0);
        chk("rst_hi", hi_out, 0);
        chk("rst_lo", lo_out, 0);
        step(); step();
        reset = 1'b1;

        // Idle for 50 cycles with no requests
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_multInit", multInit, 0);
            chk("idle_busy", busy, 0);
            chk("idle_outs", {hi_out, lo_out}, 64'h0);
            chk("idle_ops", {value_A_Mc, value_B_Mp}, 64'h0);
            chk("idle_rd", rd_data, 0);
        end

        // 7 x 6, then MFLO
        do_mult(32'd7, 32'd6, 32'h0, 1'b0);
        op_mflo = 1'b1; chk_rd(); op_mflo = 1'b0;

        // MTHI+MTLO together; same-cycle MFLO sees the old LO
        op_mthi = 1; op_mtlo = 1; rs_value = 32'hDEADBEEF; op_mflo = 1;
        chk_rd();
        step();
        op_mthi = 0; op_mtlo = 0; op_mflo = 0;
        ref_hi = 32'hDEADBEEF; ref_lo = 32'hDEADBEEF;
        chk("mt_hi", hi_out, ref_hi);
        chk("mt_lo", lo_out, ref_lo);
        chk("mt_busy", busy, 0);
        op_mfhi = 1; chk_rd(); op_mfhi = 0;

        // MTLO held through a busy multiply is taken one cycle after busy falls
        op_mtlo = 1'b1;
        do_mult(32'hFFFFFFFF, 32'd2, 32'h1234, 1'b0);
        step();
        op_mtlo = 1'b0;
        ref_lo = 32'h1234;
        chk("held_mtlo_lo", lo_out, 32'h1234);
        chk("held_mtlo_hi", hi_out, ref_hi);
        chk("held_mtlo_busy", busy, 0);

        // Second MULT held during busy starts only after busy drops
        do_mult(32'h10, 32'h20, 32'h0, 1'b1);
        do_mult(32'hABCD, 32'h1234, 32'h0, 1'b0);

        // Asynchronous reset in WAIT cycle 10
        op_mult = 1; rs_value = 32'h55; rt_value = 32'h77;
        step();
        op_mult = 0;
        repeat (9) step();
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_multInit", multInit, 0);
        chk("arst_hilo", {hi_out, lo_out}, 64'h0);
        chk("arst_ops", {value_A_Mc, value_B_Mp}, 64'h0);
        #1 reset = 1'b1;
        ref_hi = '0; ref_lo = '0;
        for (int i = 0; i < L + 4; i++) begin
            step();
            chk("post_arst_busy", busy, 0);
            chk("post_arst_hilo", {hi_out, lo_out}, 64'h0);
        end
        do_mult(32'd3, 32'd5, 32'h0, 1'b0);

        // MULT beats MTHI in the same cycle
        op_mthi = 1'b1;
        do_mult(32'h80000001, 32'h10, 32'h0, 1'b0);

        // Randomized mix against the reference HI/LO
        for (int it = 0; it < 16; it++) begin
            int k;
            k = $urandom_range(0, 2);
            if (k == 0) begin
                do_mult($urandom, $urandom, $urandom, 1'b0);
            end else if (k == 1) begin
                bit h, l;
                logic [31:0] d;
                h = 1'($urandom_range(0, 1));
                l = h ? 1'($urandom_range(0, 1)) : 1'b1;
                d = $urandom;
                op_mthi = h; op_mtlo = l; rs_value = d;
                step();
                op_mthi = 0; op_mtlo = 0;
                if (h) ref_hi = d;
                if (l) ref_lo = d;
                chk("rnd_hi", hi_out, ref_hi);
                chk("rnd_lo", lo_out, ref_lo);
                chk("rnd_busy", busy, 0);
            end else begin
                op_mfhi = 1'($urandom_range(0, 1));
                op_mflo = 1'($urandom_range(0, 1));
                chk_rd();
                op_mfhi = 0; op_mflo = 0;
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
